// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the UART command receiver: the FSM state type,
// the default bit period and the command byte values used by the consumer.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // 50 MHz / 19200 baud
    localparam int BAUD_DIV = 2604;

    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Bundle of the receiver's line-side and consumer-side signals.
// The slave modport is the receiver; the master modport is whoever drives RX
// and acknowledges bytes.
interface uart_cmd_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    modport master (output RX, output clr_rdy,
                    input  rx_data, input rdy, input frm_err);
    modport slave  (input  RX, input clr_rdy,
                    output rx_data, output rdy, output frm_err);
endinterface

// File: rtl/uart_cmd_rx_synch.sv
// RX line synchronizer: two metastability flops plus a delay flop, all
// preset to the idle (high) level so reset never looks like a start edge
// on an idle line. start_det_o flags a high-to-low transition.
module rx_synch (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic sync_o,
    output logic start_det_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Shift the raw line through the synchronizer and edge-detect flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sync_o      = sync2_q;
    assign start_det_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 serial command receiver. Samples each bit at mid-bit, presents the
// byte on rx_data with a sticky rdy that the consumer clears via clr_rdy.
// Optional macro UART_FRAME_CHK_EN: reject frames whose stop bit is 0 and
// pulse frm_err for one clock instead of raising rdy.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = uart_pkg::BAUD_DIV,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_rx_if.slave  bus
);
    localparam int CW = $clog2(BAUD_DIV);

    state_t          state_q,    state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]      bit_cnt_q,  bit_cnt_d;
    logic [8:0]      shift_q,    shift_d;
    logic            rdy_q,      rdy_d;
    logic [7:0]      rx_data_q,  rx_data_d;

    logic            rx_sync;
    logic            start_det;
    logic            done;
    logic            stop_ok;
    logic            unused_start_bit;

    rx_synch u_synch (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (bus.RX),
        .sync_o      (rx_sync),
        .start_det_o (start_det)
    );

    // The start-bit sample falls off the bottom of the shift register
    assign unused_start_bit = shift_q[0];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= 9'h1FF;
            rdy_q      <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rdy_q      <= rdy_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Next state: wait for a start edge, then sample ten bits at mid-bit.
    // The counter treats zero as a cycle of its own, so loads are one less
    // than the intended distance to keep the bit period exact.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d    = RECV;
                    baud_cnt_d = CW'(HALF_DIV - 1);
                    bit_cnt_d  = '0;
                end
            end
            RECV: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {rx_sync, shift_q[8:1]};
                    baud_cnt_d = CW'(BAUD_DIV - 1);
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_FRAME_CHK_EN
    assign stop_ok = shift_d[8];
`else
    assign stop_ok = 1'b1;
`endif

    // Outputs: rdy cleared by an accepted start edge or clr_rdy; a good
    // completion sets it and wins over a simultaneous clr_rdy.
    always_comb begin
        rdy_d     = rdy_q;
        rx_data_d = rx_data_q;
        if ((state_q == IDLE) && start_det) begin
            rdy_d = 1'b0;
        end
        if (bus.clr_rdy) begin
            rdy_d = 1'b0;
        end
        if (done && stop_ok) begin
            rdy_d     = 1'b1;
            rx_data_d = shift_d[7:0];
        end
    end

`ifdef UART_FRAME_CHK_EN
    logic frm_err_q;
    logic frm_err_d;

    assign frm_err_d = done & ~stop_ok;

    // One-clock framing error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= frm_err_d;
        end
    end

    assign bus.frm_err = frm_err_q;
`else
    assign bus.frm_err = 1'b0;
`endif

    assign bus.rdy     = rdy_q;
    assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx, run with a short bit period so many frames fit.
module tb_uart_cmd_rx;
    import uart_pkg::*;

    localparam int B        = 16;
    localparam int H        = B / 2;
    localparam int LAT_SPEC = 2 + H + 9 * B;
`ifdef UART_FRAME_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_cmd_rx_if bus_if ();

    uart_cmd_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    int   frm_cnt  = 0;
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_if.rdy && !rdy_prev) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        rdy_prev <= bus_if.rdy;
        if (bus_if.frm_err) frm_cnt <= frm_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int c0     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rdy must rise within 3 clocks of the nominal latency after the start edge
    task automatic check_lat(input string name);
        int lat;
        lat = rise_cyc - c0;
        checks++;
        if (lat < LAT_SPEC - 3 || lat > LAT_SPEC + 3) begin
            errors++;
            $display("FAIL %s: latency %0d expected %0d +-3", name, lat, LAT_SPEC);
        end
    endtask

    // Drive one frame; caller is at a falling edge, returns at a falling edge
    task automatic send(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            bus_if.RX = fr[i];
            repeat (B) @(negedge clk);
        end
        bus_if.RX = 1'b1;
    endtask

    task automatic pulse_clr();
        bus_if.clr_rdy = 1'b1;
        @(negedge clk);
        bus_if.clr_rdy = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_rdy;
        logic [7:0] exp_data;
        int         exp_frm;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];

    initial begin
        int base_rise, base_frm;
        logic [7:0] d, e;

        vecs[0] = '{8'h47, 1'b1, 1'b1, 8'h47, 0};
        vecs[1] = '{8'h53, 1'b1, 1'b1, 8'h53, 0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[5] = '{8'h47, 1'b0, !CHK, CHK ? 8'hFF : 8'h47, CHK ? 1 : 0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[7] = '{8'h01, 1'b0, !CHK, CHK ? 8'h80 : 8'h01, CHK ? 1 : 0};

        bus_if.RX = 1'b1;
        bus_if.clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rdy", bus_if.rdy, 1'b0);
        check("reset_data", bus_if.rx_data, 8'h00);
        check("reset_frm", bus_if.frm_err, 1'b0);

        // Idle line: nothing happens
        repeat (2000) @(negedge clk);
        check("idle_rdy", bus_if.rdy, 1'b0);
        check("idle_data", bus_if.rx_data, 8'h00);
        check("idle_rise", rise_cnt, 0);

        // 'G', then acknowledge
        send(CMD_GO, 1'b1);
        repeat (2) @(negedge clk);
        check("go_rdy", bus_if.rdy, 1'b1);
        check("go_data", bus_if.rx_data, CMD_GO);
        check_lat("go_latency");
        pulse_clr();
        check("clr_rdy", bus_if.rdy, 1'b0);
        pulse_clr();
        check("clr_idle_rdy", bus_if.rdy, 1'b0);
        check("clr_idle_data", bus_if.rx_data, CMD_GO);

        // Table of single frames, including bad stop bits
        for (int i = 0; i < 8; i++) begin
            base_frm = frm_cnt;
            send(vecs[i].data, vecs[i].stop);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_rdy", i), bus_if.rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_data", i), bus_if.rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_frm", i), frm_cnt - base_frm, vecs[i].exp_frm);
            if (vecs[i].exp_rdy) check_lat($sformatf("vec%0d_latency", i));
            repeat ($urandom_range(0, B)) @(negedge clk);
        end

        // Back-to-back 'S' then 0xA5 without acknowledging
        send(CMD_STOP, 1'b1);
        check("b2b_first_data", bus_if.rx_data, CMD_STOP);
        check("b2b_first_rdy", bus_if.rdy, 1'b1);
        fork
            send(8'hA5, 1'b1);
            begin
                repeat (5 * B) @(negedge clk);
                check("b2b_mid_rdy", bus_if.rdy, 1'b0);
                check("b2b_mid_data", bus_if.rx_data, CMD_STOP);
            end
        join
        repeat (2) @(negedge clk);
        check("b2b_second_data", bus_if.rx_data, 8'hA5);
        check("b2b_second_rdy", bus_if.rdy, 1'b1);
        check_lat("b2b_latency");

        // clr_rdy exactly on the completion cycle
        fork
            send(8'h5A, 1'b1);
            begin
                repeat (2 + H + 9 * B) @(negedge clk);
                pulse_clr();
            end
        join
        repeat (2) @(negedge clk);
        check("setwins_rdy", bus_if.rdy, 1'b1);
        check("setwins_data", bus_if.rx_data, 8'h5A);

        // Break: line held low for several frame times
        pulse_clr();
        base_rise = rise_cnt;
        base_frm  = frm_cnt;
        bus_if.RX = 1'b0;
        repeat (30 * B) @(negedge clk);
        check("break_rises", rise_cnt - base_rise, CHK ? 0 : 1);
        check("break_frm", frm_cnt - base_frm, CHK ? 1 : 0);
        check("break_data", bus_if.rx_data, CHK ? 8'h5A : 8'h00);
        bus_if.RX = 1'b1;
        repeat (2 * B) @(negedge clk);

        // Reset during bit 4 of 'G'
        base_rise = rise_cnt;
        begin
            logic [9:0] fr;
            fr = {1'b1, CMD_GO, 1'b0};
            for (int i = 0; i < 5; i++) begin
                bus_if.RX = fr[i];
                repeat (B) @(negedge clk);
            end
            bus_if.RX = fr[5];
            repeat (H) @(negedge clk);
        end
        rst = 1'b1;
        bus_if.RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * B) @(negedge clk);
        check("rstmid_rdy", bus_if.rdy, 1'b0);
        check("rstmid_data", bus_if.rx_data, 8'h00);
        check("rstmid_rises", rise_cnt - base_rise, 0);
        send(CMD_STOP, 1'b1);
        repeat (2) @(negedge clk);
        check("rstmid_next_rdy", bus_if.rdy, 1'b1);
        check("rstmid_next_data", bus_if.rx_data, CMD_STOP);

        // Random bytes against a queue model
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send(d, 1'b1);
            repeat (2) @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("rand%0d_data", i), bus_if.rx_data, e);
            check($sformatf("rand%0d_rdy", i), bus_if.rdy, 1'b1);
            check_lat($sformatf("rand%0d_latency", i));
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                check($sformatf("rand%0d_clr", i), bus_if.rdy, 1'b0);
            end
            repeat ($urandom_range(0, 3 * B)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
